countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 128 ++++++++++++
 tb/tb_countdown_timer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable 4-bit down-counter with run/done handshake.
// Q0..Q3 feed the downstream 4-bit zero detector; is_zero mirrors it locally.
// Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN
//   defined   -> adds reload register and 'auto' input for periodic operation
//   undefined -> one-shot delay only
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no delay pending, Q = 0, waiting for load
// RUN   | counting down on tick, Q in 1..15
// DONE  | delay expired, Q = 0, done held until ack (or a new load)
// 2'b11 | illegal, recovers to IDLE with Q = 0 on the next edge
module countdown_timer (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic load,
  input  logic L0,
  input  logic L1,
  input  logic L2,
  input  logic L3,
  input  logic ack,
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  input  logic auto,
`endif
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic busy,
  output logic done,
  output logic is_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;
  logic [3:0] count;
  logic [3:0] loadVal;
  logic loadNonZero;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [3:0] reloadVal;
`endif

  assign loadVal     = {L3, L2, L1, L0};
  assign loadNonZero = |loadVal;

  // Sequencer: state, count and registered Moore outputs advance together.
  // A zero-length load goes straight to DONE so RUN never holds Q = 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reloadVal <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            count <= loadVal;
            state <= loadNonZero ? RUN : DONE;
            busy  <= loadNonZero;
            done  <= ~loadNonZero;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reloadVal <= loadVal;
`endif
          end else if ((state == DONE) && ack) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (load) begin
            count <= loadVal;
            state <= loadNonZero ? RUN : DONE;
            busy  <= loadNonZero;
            done  <= ~loadNonZero;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reloadVal <= loadVal;
`endif
          end else if (tick && (count == 4'd1)) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            if (auto) begin
              // Periodic mode: restart from the captured length, one-cycle done pulse.
              count <= reloadVal;
              done  <= 1'b1;
            end else
`endif
            begin
              count <= 4'd0;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            if (tick) count <= count - 4'd1;
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          count <= 4'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Count bits straight from the register; is_zero decodes only registered state.
  always_comb begin
    Q0      = count[0];
    Q1      = count[1];
    Q2      = count[2];
    Q3      = count[3];
    is_zero = (count == 4'd0);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, hand-written corner
// sequences and a randomized run against a remaining-ticks reference model.
module tb_countdown_timer;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit HAS_AUTO = 1'b1;
`else
  localparam bit HAS_AUTO = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic tick, load, ack, autoIn;
  logic [3:0] lVal;
  logic q0, q1, q2, q3, busy, done, isZero;
  logic [3:0] qVal;

  int tests = 0;
  int failures = 0;

  // Reference model: remaining ticks, ack-pending flag, period and pulse flag.
  int mRem, mPeriod;
  bit mWait, mPulse;

  assign qVal = {q3, q2, q1, q0};

  always #5 clock = ~clock;

  countdown_timer dut (
    .clock(clock),
    .reset(reset),
    .tick(tick),
    .load(load),
    .L0(lVal[0]),
    .L1(lVal[1]),
    .L2(lVal[2]),
    .L3(lVal[3]),
    .ack(ack),
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    .auto(autoIn),
`endif
    .Q0(q0),
    .Q1(q1),
    .Q2(q2),
    .Q3(q3),
    .busy(busy),
    .done(done),
    .is_zero(isZero)
  );

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       tk;
    logic       ak;
    logic [3:0] q;
    logic       bz;
    logic       dn;
  } vec_t;

  vec_t vecs[28];

  task automatic modelReset();
    mRem = 0; mPeriod = 0; mWait = 0; mPulse = 0;
  endtask

  task automatic modelStep(input logic ld, input logic [3:0] lv, input logic tk,
                           input logic ak, input logic au);
    bit pulseNow;
    pulseNow = 0;
    if (ld) begin
      mRem = lv;
      mPeriod = lv;
      mWait = (lv == 0);
    end else if (mRem > 0) begin
      if (tk) begin
        mRem = mRem - 1;
        if (mRem == 0) begin
          if (au && HAS_AUTO) begin
            mRem = mPeriod;
            pulseNow = 1;
          end else begin
            mWait = 1;
          end
        end
      end
    end else if (mWait && ak) begin
      mWait = 0;
    end
    mPulse = pulseNow;
  endtask

  task automatic check(input string name, input logic [3:0] eq, input logic eb,
                       input logic ed, input logic ez);
    tests++;
    if (qVal !== eq || busy !== eb || done !== ed || isZero !== ez) begin
      failures++;
      $display("FAIL %s: got Q=%0d busy=%b done=%b is_zero=%b, expected Q=%0d busy=%b done=%b is_zero=%b",
               name, qVal, busy, done, isZero, eq, eb, ed, ez);
    end
  endtask

  task automatic checkModel(input string name);
    check(name, 4'(mRem), mRem > 0, mWait || mPulse, mRem == 0);
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input logic ld, input logic [3:0] lv, input logic tk,
                      input logic ak, input logic au);
    load = ld; lVal = lv; tick = tk; ack = ak; autoIn = au;
    @(posedge clock);
    #1;
    modelStep(ld, lv, tk, ak, au);
  endtask

  task automatic doReset();
    reset = 1'b1;
    load = 0; lVal = 0; tick = 0; ack = 0; autoIn = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[23] = '{1'b1, 4'd4, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
    vecs[25] = '{1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[26] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};

    modelReset();
    reset = 1'b1;
    load = 0; lVal = 0; tick = 0; ack = 0; autoIn = 0;
    #12;
    check("reset_state", 4'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset mid-run: asynchronous clear between edges, no done afterwards.
    step(1, 4'd9, 0, 0, 0);
    check("midrun_load", 4'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 4'd0, 1, 0, 0);
    check("midrun_3ticks", 4'd6, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("midrun_async_reset", 4'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
    for (int i = 0; i < 12; i++) begin
      step(0, 4'd0, 1, 0, 0);
      check($sformatf("post_reset_idle_%0d", i), 4'd0, 1'b0, 1'b0, 1'b1);
    end

    // Directed table: basic delay, gated ticks, zero load, restart, priorities.
    for (int i = 0; i < 28; i++) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].tk, vecs[i].ak, 1'b0);
      check($sformatf("vec_%0d", i), vecs[i].q, vecs[i].bz, vecs[i].dn, vecs[i].q == 4'd0);
    end

    // Full range: 15 ticks, no wrap, DONE holds under further ticks.
    step(1, 4'd15, 0, 0, 0);
    check("full_load", 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      step(0, 4'd0, 1, 0, 0);
      check($sformatf("full_tick_%0d", i), 4'(15 - i), i < 15, i == 15, i == 15);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 4'd0, 1, 0, 0);
      check($sformatf("done_hold_%0d", i), 4'd0, 1'b0, 1'b1, 1'b1);
    end
    step(0, 4'd0, 0, 1, 0);
    check("full_ack", 4'd0, 1'b0, 1'b0, 1'b1);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // Periodic mode: period 3, one-cycle done pulses, then fall back to one-shot.
    doReset();
    step(1, 4'd3, 1, 0, 1);
    check("auto_load", 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 4'd0, 1, 0, 1);
      check($sformatf("auto_tick_%0d", i), (i % 3 == 0) ? 4'd3 : 4'(3 - i % 3),
            1'b1, i % 3 == 0, 1'b0);
    end
    step(0, 4'd0, 0, 0, 1);
    check("auto_pulse_clear", 4'd3, 1'b1, 1'b0, 1'b0);
    step(0, 4'd0, 1, 0, 0);
    check("auto_off_2", 4'd2, 1'b1, 1'b0, 1'b0);
    step(0, 4'd0, 1, 0, 0);
    check("auto_off_1", 4'd1, 1'b1, 1'b0, 1'b0);
    step(0, 4'd0, 1, 0, 0);
    check("auto_off_done", 4'd0, 1'b0, 1'b1, 1'b1);
    step(0, 4'd0, 1, 0, 1);
    check("auto_off_hold", 4'd0, 1'b0, 1'b1, 1'b1);
`endif

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 800; i++) begin
      logic rl, rt, ra, rau;
      logic [3:0] rv;
      rl  = ($urandom_range(0, 9) == 0);
      rv  = 4'($urandom_range(0, 15));
      rt  = ($urandom_range(0, 3) != 0);
      ra  = ($urandom_range(0, 3) == 0);
      rau = HAS_AUTO ? ($urandom_range(0, 1) == 1) : 1'b0;
      step(rl, rv, rt, ra, rau);
      checkModel($sformatf("rand_%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
